fetch_stage: RTL and testbench



---
 rtl/rv32i_pkg.sv | 16 +
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, canonical NOP and the IF/ID pipeline record.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0000_0000, pc4: 32'h0000_0000};

endpackage

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, drives the combinational instruction memory,
// and registers the fetched word into IF/ID with stall, redirect/squash and sticky halt.
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic            halted
);

    localparam logic [29:0] DEPTH_WORDS = 30'(IMEM_DEPTH);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_next_s;
    logic [XLEN-1:0] pc_plus4_s;
    if_id_t          if_id_r;
    if_id_t          if_id_next_s;
    logic            halted_r;
    logic            halted_next_s;
    logic            oob_s;

    assign pc_plus4_s = pc_r + 32'd4;
    assign oob_s      = (pc_r[31:2] >= DEPTH_WORDS);

    // Next-PC mux; the priority order here must match the IF/ID mux below.
    always_comb begin
        pc_next_s = pc_r;
        if (redirect_valid) begin
            pc_next_s = redirect_target & 32'hFFFF_FFFC;
        end else if (halted_r || stall || oob_s) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Next IF/ID contents and halt flag; a stall holds both, a redirect squashes and un-halts.
    always_comb begin
        if_id_next_s  = if_id_r;
        halted_next_s = halted_r;
        if (redirect_valid) begin
            if_id_next_s  = IF_ID_BUBBLE;
            halted_next_s = 1'b0;
        end else if (halted_r) begin
            if_id_next_s  = IF_ID_BUBBLE;
            halted_next_s = 1'b1;
        end else if (stall) begin
            if_id_next_s  = if_id_r;
            halted_next_s = halted_r;
        end else if (oob_s) begin
            if_id_next_s  = IF_ID_BUBBLE;
            halted_next_s = 1'b1;
        end else begin
            if_id_next_s  = '{valid: 1'b1, instr: imem_instr, pc: pc_r, pc4: pc_plus4_s};
            halted_next_s = 1'b0;
        end
    end

    // IF/ID pipeline register and sticky halt flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_id_r  <= IF_ID_BUBBLE;
            halted_r <= 1'b0;
        end else begin
            if_id_r  <= if_id_next_s;
            halted_r <= halted_next_s;
        end
    end

    assign imem_addr   = pc_r;
    assign if_id_valid = if_id_r.valid;
    assign if_id_instr = if_id_r.instr;
    assign if_id_pc    = if_id_r.pc;
    assign if_id_pc4   = if_id_r.pc4;
    assign halted      = halted_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised and directed bench for fetch_stage against a sequential reference model.
module tb_fetch_stage;
    import rv32i_pkg::*;

    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          DEPTH = 24;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect_valid;
    logic [31:0] redirect_target, imem_addr, imem_instr;
    logic        if_id_valid, halted;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc4;

    logic [31:0] mem [0:DEPTH-1];

    // Reference model state: an abstract fetcher (next PC, latched record, halt flag).
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
    logic        m_valid, m_halt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        int idx;
        idx = int'(addr >> 2);
        if (addr < 32'(DEPTH * 4)) return mem[idx];
        return 32'hBAD0_BAD0;
    endfunction

    assign imem_instr = mem_read(imem_addr);

    fetch_stage #(.RESET_PC(RPC), .IMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .halted(halted)
    );

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic bubble();
        m_valid = 1'b0; m_instr = 32'h0000_0013; m_ipc = 32'h0; m_ipc4 = 32'h0;
    endtask

    // One clock: apply inputs, advance model by the rules, compare all outputs after the edge.
    task automatic cycle(input logic r, input logic s, input logic rv, input logic [31:0] rt);
        rst_n = r; stall = s; redirect_valid = rv; redirect_target = rt;
        @(posedge clk);
        if (!r) begin
            m_pc = RPC; bubble(); m_halt = 1'b0;
        end else if (rv) begin
            m_pc = {rt[31:2], 2'b00}; bubble(); m_halt = 1'b0;
        end else if (m_halt) begin
            bubble();
        end else if (s) begin
            m_pc = m_pc;
        end else if ((m_pc >> 2) >= 32'(DEPTH)) begin
            m_halt = 1'b1; bubble();
        end else begin
            m_valid = 1'b1; m_instr = mem[int'(m_pc >> 2)];
            m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
        end
        #1;
        check32("imem_addr", imem_addr, m_pc);
        check32("valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check32("instr", if_id_instr, m_instr);
        check32("pc", if_id_pc, m_ipc);
        check32("pc4", if_id_pc4, m_ipc4);
        check32("halted", {31'd0, halted}, {31'd0, m_halt});
    endtask

    task automatic run_to_pc(input logic [31:0] target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (m_pc == target) break;
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
        end
        check32("reach_pc", imem_addr, target);
    endtask

    initial begin
        logic [31:0] held_pc, rt;
        logic        r, s, rv;
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + 32'(i);

        // Reset, then free-run.
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h40);
        check32("rst_instr", if_id_instr, 32'h0000_0013);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check32("run_pc", if_id_pc, 32'h8);
        check32("run_instr", if_id_instr, 32'h102);

        // Stall three cycles with pc=8 held, then pc=12 with no gap.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check32("stall_hold", if_id_pc, 32'h8);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check32("stall_resume", if_id_pc, 32'hC);

        // Redirect to 0x12 while at pc=4.
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        run_to_pc(32'h4, 4);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0012);
        check32("redir_addr", imem_addr, 32'h10);
        check32("redir_bubble", {31'd0, if_id_valid}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check32("redir_pc", if_id_pc, 32'h10);
        check32("redir_instr", if_id_instr, 32'h104);

        // Redirect together with stall: redirect wins.
        cycle(1'b1, 1'b1, 1'b1, 32'h0);
        check32("both_instr", if_id_instr, 32'h0000_0013);
        check32("both_addr", imem_addr, 32'h0);

        // Free-run off the end of memory, then recover with a redirect.
        run_to_pc(32'h60, 40);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check32("oob_halt", {31'd0, halted}, 32'h1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check32("oob_hold", imem_addr, 32'h60);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check32("halt_stall", {31'd0, halted}, 32'h1);
        cycle(1'b1, 1'b0, 1'b1, 32'h0);
        check32("unhalt", {31'd0, halted}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check32("resume_instr", if_id_instr, 32'h100);

        // Reset while stalled at pc=0x20.
        run_to_pc(32'h20, 20);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        held_pc = if_id_pc;
        check32("pre_rst_pc", held_pc, 32'h1C);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check32("rst_addr", imem_addr, RPC);
        check32("rst_pc", if_id_pc, 32'h0);

        // Randomised phase with random memory contents.
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 99) >= 2);
            s  = ($urandom_range(0, 99) < 25);
            rv = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 3))
                0:       rt = $urandom;
                1:       rt = 32'h50 + 32'($urandom_range(0, 15));
                default: rt = 32'($urandom_range(0, DEPTH * 4 - 1));
            endcase
            cycle(r, s, rv, rt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
